// File: rtl/regfile_param_if.sv
`timescale 1ns/1ps
// regfile_param_if
// Bundles the read, write and clear signals of the parameterised register
// file so that the design and its users share one port definition.
//
// Signals
//   rd_addr1, rd_addr2 : read port addresses
//   rd_data1, rd_data2 : read port data, combinational
//   wr_en, wr_addr, wr_data : write request
//   clr_req            : request a sequential clear of every entry
//   busy               : high while the clear sequence runs
//   wr_err             : one-cycle pulse when a write was dropped
//
// Modports
//   master : the side that issues reads/writes/clears
//   slave  : the register file itself
interface regfile_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              busy;
  logic              wr_err;

  modport master (
    output rd_addr1,
    output rd_addr2,
    output wr_en,
    output wr_addr,
    output wr_data,
    output clr_req,
    input  rd_data1,
    input  rd_data2,
    input  busy,
    input  wr_err
  );

  modport slave (
    input  rd_addr1,
    input  rd_addr2,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  clr_req,
    output rd_data1,
    output rd_data2,
    output busy,
    output wr_err
  );

endinterface

// File: rtl/regfile_param.sv
`timescale 1ns/1ps
// regfile_param
// Parameterised register file with two asynchronous read ports, one write
// port, an optional hard-wired zero entry, optional write-first bypass and
// a sequential clear engine that wipes one entry per clock.
//
// Parameters
//   DATA_W   : width of each entry
//   ADDR_W   : address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG : when nonzero, entry 0 reads 0 and ignores writes
//   BYPASS   : when nonzero, reads see an accepted same-cycle write
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-high reset (entries, FSM, flags to 0)
//   bus   : regfile_param_if slave modport carrying read/write/clear signals
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  regfile_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] clr_idx_next;
  logic              wr_err_q;
  logic              wr_err_next;

  logic [DATA_W-1:0] mem [DEPTH];

  // Local copies of the interface inputs keep the datapath expressions short.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              clr_req;

  assign wr_en    = bus.wr_en;
  assign wr_addr  = bus.wr_addr;
  assign wr_data  = bus.wr_data;
  assign rd_addr1 = bus.rd_addr1;
  assign rd_addr2 = bus.rd_addr2;
  assign clr_req  = bus.clr_req;

  logic wr_to_zero;
  logic write_ok;

  // A write is only taken in IDLE; a write aimed at the hard-wired zero
  // entry is silently discarded and is not reported as an error.
  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign write_ok   = wr_en && (state == IDLE) && !wr_to_zero;

  // State register, clear index and error flag. The flag records that a
  // write arrived while clearing, so it appears for exactly the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_idx  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state    <= state_next;
      clr_idx  <= clr_idx_next;
      wr_err_q <= wr_err_next;
    end
  end

  // Next-state logic. A clear runs exactly DEPTH cycles; further clr_req
  // pulses while clearing are ignored, and the index wraps back to 0 on the
  // final increment so the next clear starts from entry 0 again.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    wr_err_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      CLEAR: begin
        clr_idx_next = clr_idx + 1'b1;
        wr_err_next  = wr_en;
        if (clr_idx == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_idx_next = '0;
      end
    endcase
  end

  // Storage. Reset wipes every entry at once; while clearing, the engine
  // owns the write path. When a write and clr_req coincide in IDLE the write
  // lands first and the following clear sequence overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (write_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port 1. write_ok is only true in IDLE, so bypass is automatically
  // off while a clear runs and the port shows the partially cleared array.
  always_comb begin
    bus.rd_data1 = mem[rd_addr1];
    if ((BYPASS != 0) && write_ok && (wr_addr == rd_addr1)) begin
      bus.rd_data1 = wr_data;
    end
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
      bus.rd_data1 = '0;
    end
  end

  // Read port 2, identical to port 1 and bypassed independently of it.
  always_comb begin
    bus.rd_data2 = mem[rd_addr2];
    if ((BYPASS != 0) && write_ok && (wr_addr == rd_addr2)) begin
      bus.rd_data2 = wr_data;
    end
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
      bus.rd_data2 = '0;
    end
  end

  // busy follows the state register directly, so it drops the moment reset
  // is asserted and needs no separate flop.
  assign bus.busy   = (state == CLEAR);
  assign bus.wr_err = wr_err_q;

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 16, width of each register entry in bits.
REQ-002 Parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 always reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1, when 1 read ports return same-cycle write data (write-first).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rd_addr1  input  ADDR_W  read port 1 address.
REQ-008 rd_addr2  input  ADDR_W  read port 2 address.
REQ-009 rd_data1  output  DATA_W  read port 1 data, combinational.
REQ-010 rd_data2  output  DATA_W  read port 2 data, combinational.
REQ-011 wr_en  input  1  write request.
REQ-012 wr_addr  input  ADDR_W  write address.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 clr_req  input  1  request sequential clear of all entries.
REQ-015 busy  output  1  high while clear sequence runs.
REQ-016 wr_err  output  1  one-cycle pulse: a write was dropped.

Function
REQ-017 States: IDLE, CLEAR; clear counter clr_idx of ADDR_W bits.
REQ-018 Write accepted when wr_en=1 and state=IDLE: entry[wr_addr] <= wr_data at rising edge.
REQ-019 ZERO_REG=1: write to address 0 discarded, no wr_err; reads of address 0 return 0.
REQ-020 Reads asynchronous: rd_dataN = entry[rd_addrN], subject to REQ-019/REQ-021.
REQ-021 BYPASS=1: accepted write with wr_addr==rd_addrN (nonzero if ZERO_REG=1) -> rd_dataN = wr_data same cycle; both ports bypass independently.
REQ-022 BYPASS=0: reads return stored value; new value visible after the edge.
REQ-023 IDLE and clr_req=1 at edge -> CLEAR, clr_idx=0, busy=1 from next cycle.
REQ-024 CLEAR: each edge entry[clr_idx] <= 0, clr_idx increments; exactly DEPTH cycles in CLEAR.
REQ-025 Edge clearing entry DEPTH-1 -> IDLE, busy=0 next cycle; clr_idx wraps to 0.
REQ-026 clr_req in CLEAR ignored; no restart, no extension.
REQ-027 wr_en=1 in CLEAR: write dropped, wr_err=1 for the following cycle only.
REQ-028 Bypass disabled while busy=1; reads return current (partially cleared) storage.
REQ-029 Same edge wr_en=1 and clr_req=1 in IDLE: write accepted, then clear overwrites it.
REQ-030 busy is registered, derived only from state; wr_err registered.

Reset
REQ-031 reset=1 asynchronously: all entries 0, state IDLE, clr_idx 0, busy 0, wr_err 0.
REQ-032 reset mid-clear aborts sequence; after release block is IDLE with all entries 0.
REQ-033 Writes with reset=1 have no effect; first accepted write is at first edge after release.

Verification
REQ-034 Write 0x1234 to 5, next cycle rd_addr1=5 -> rd_data1=0x1234; rd_addr2=6 -> 0x0000.
REQ-035 BYPASS=1: wr_en, wr_addr=3, wr_data=0xBEEF, rd_addr1=3 same cycle -> rd_data1=0xBEEF before edge.
REQ-036 ZERO_REG=1: write 0xFFFF to 0 -> rd_data1 at address 0 = 0x0000, wr_err=0.
REQ-037 Fill entries 1..15 with 0xA5A5, pulse clr_req -> busy high exactly 16 cycles; afterwards all reads 0.
REQ-038 Write 0x0F0F to 7 during CLEAR -> wr_err=1 one cycle, entry 7 reads 0 after clear.
REQ-039 Assert reset at clear cycle 4 -> busy=0 immediately, all entries 0, write to 2 after release succeeds.
